// File: rtl/simple_cpu_sequencer.sv
// simple_cpu_sequencer
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the SimpleCPU datapath.
// Fetches 16-bit instructions over a req/ready handshake into an instruction
// register feeding the decoder, gates the decoder write-enable into a single
// writeback cycle, advances the PC and counts retired instructions.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   start             - launch from PC 0 (honoured only in IDLE or HALT)
//   imem_req/addr     - fetch request and address (addr == pc)
//   imem_ready/rdata  - fetch response, same-cycle handshake
//   ins               - instruction register to the decoder
//   dec_we            - decoder register-write-enable for ins
//   rf_we             - register-file write strobe (WB only)
//   busy, halted      - status flags
//   pc                - current instruction address, wraps modulo 2^PC_W
//   retired           - saturating retired-instruction count
module simple_cpu_sequencer #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ins,
    input  logic            dec_we,
    output logic            rf_we,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ins;
    logic [15:0]     r_retired;
    logic            w_is_halt;

    assign w_is_halt = (r_ins[15:9] == 7'h7F);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        rf_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                busy   = 1'b1;
                w_next = w_is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                busy   = 1'b1;
                w_next = S_WB;
            end
            S_WB: begin
                busy   = 1'b1;
                // Decoded from state so an async reset drops the strobe at once.
                rf_we  = dec_we;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_ins     <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc      <= '0;
                        r_retired <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) r_ins <= imem_rdata;
                end
                S_WB: begin
                    r_pc <= r_pc + PC_W'(1);
                    if (r_retired != '1) r_retired <= r_retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ins       = r_ins;
    assign retired   = r_retired;

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Testbench for simple_cpu_sequencer: a table-driven zero-wait program, hand
// sequences for wait states, unrecognised opcodes, start handling, async reset
// mid-WB and PC wrap (second instance, PC_W=2), plus randomized programs with
// random wait states checked against a per-instruction timeline model.
module tb_simple_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ins;
    logic        dec_we;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] retired;

    logic        w2_start;
    logic        w2_req;
    logic [1:0]  w2_addr;
    logic        w2_ready;
    logic [15:0] w2_ins;
    logic        w2_dec_we;
    logic        w2_rf_we;
    logic        w2_busy;
    logic        w2_halted;
    logic [1:0]  w2_pc;
    logic [15:0] w2_ret;

    logic [15:0] mem [0:255];
    logic        r_rdy;

    always #5 clk = ~clk;

    // Memory answers only while a request is outstanding; decoder stand-in
    // recognises opcodes with bit 15 clear.
    assign imem_ready = r_rdy & imem_req;
    assign imem_rdata = mem[imem_addr];
    assign dec_we     = ~ins[15];

    assign w2_ready  = w2_req;
    assign w2_dec_we = ~w2_ins[15];

    simple_cpu_sequencer #(.PC_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ins(ins), .dec_we(dec_we), .rf_we(rf_we),
        .busy(busy), .halted(halted), .pc(pc), .retired(retired)
    );

    simple_cpu_sequencer #(.PC_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w2_start),
        .imem_req(w2_req), .imem_addr(w2_addr),
        .imem_ready(w2_ready), .imem_rdata(16'h8000),
        .ins(w2_ins), .dec_we(w2_dec_we), .rf_we(w2_rf_we),
        .busy(w2_busy), .halted(w2_halted), .pc(w2_pc), .retired(w2_ret)
    );

    int n_vec = 0;
    int n_err = 0;

    // Table row: inputs for the cycle, then expected {req,busy,halted,rf_we,pc,retired}.
    typedef struct packed {
        logic        start;
        logic        rdy;
        logic        req;
        logic        busy;
        logic        halted;
        logic        rf;
        logic [7:0]  pc;
        logic [15:0] ret;
    } vec_t;

    typedef struct packed {
        logic        req;
        logic        busy;
        logic        halted;
        logic        rf;
        logic [7:0]  pc;
        logic [15:0] ret;
    } exp_t;

    vec_t        vec [0:12];
    exp_t        tl [0:255];
    logic        rdy_s [0:255];
    logic [15:0] ins_s [0:255];
    int          tlen;
    logic [15:0] prog [0:31];
    int          wts [0:31];
    int          nprog;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] snap();
        return {4'b0, imem_req, busy, halted, rf_we, pc, retired};
    endfunction

    function automatic exp_t mk(logic rq, logic bz, logic ht, logic rf, int k);
        exp_t e;
        e.req = rq; e.busy = bz; e.halted = ht; e.rf = rf;
        e.pc = 8'(k); e.ret = 16'(k);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs from the instruction list: instruction k
    // fetches for wts[k]+1 cycles, then two cycles of decode/exec, then WB;
    // HALT shows up two cycles after its handshake.
    task automatic build_timeline();
        int f;
        int h;
        for (int c = 0; c < 256; c++) begin
            tl[c] = '0; rdy_s[c] = 1'b0; ins_s[c] = '0;
        end
        f = 1;
        tlen = 0;
        for (int k = 0; k < nprog; k++) begin
            h = f + wts[k];
            for (int c = f; c <= h; c++) begin
                tl[c] = mk(1'b1, 1'b1, 1'b0, 1'b0, k);
                rdy_s[c] = (c == h);
            end
            tl[h+1] = mk(1'b0, 1'b1, 1'b0, 1'b0, k);
            ins_s[h+1] = prog[k];
            if (prog[k][15:9] == 7'h7F) begin
                tl[h+2] = mk(1'b0, 1'b0, 1'b1, 1'b0, k);
                tl[h+3] = tl[h+2];
                ins_s[h+2] = prog[k]; ins_s[h+3] = prog[k];
                tlen = h + 4;
                break;
            end
            tl[h+2] = mk(1'b0, 1'b1, 1'b0, 1'b0, k);
            tl[h+3] = mk(1'b0, 1'b1, 1'b0, ~prog[k][15], k);
            ins_s[h+2] = prog[k]; ins_s[h+3] = prog[k];
            f = h + 4;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; w2_start = 1'b0; r_rdy = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFE00;
        #1;
        chk("reset_async_outputs", snap(), 32'h0);
        chk("reset_ins_addr", {ins, imem_addr}, 24'h0);
        #20;
        rst_n = 1'b1;
        tick();
        chk("reset_idle_hold", snap(), 32'h0);

        // Unrecognised opcode, start during EXEC, reset in the middle of WB.
        mem[0] = 16'h8000; mem[1] = 16'h0000; mem[2] = 16'hFE00;
        start = 1'b1; tick(); start = 1'b0;
        chk("a_fetch0", {imem_req, busy, imem_addr}, {2'b11, 8'd0});
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("a_unrec_wb", {busy, rf_we, pc, retired}, {2'b10, 8'd0, 16'd0});
        tick();
        chk("a_exec_start_ignored", {imem_req, pc, retired, imem_addr}, {1'b1, 8'd1, 16'd1, 8'd1});
        tick(); tick(); tick();
        chk("a_wb_rf_we", {busy, rf_we}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("a_reset_mid_wb", snap(), 32'h0);
        chk("a_reset_mid_wb_ins", {ins, imem_addr}, 24'h0);
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("a_idle_after_reset", snap(), 32'h0);

        // Zero-wait program ADD, SUB, HALT.
        mem[0] = 16'h0000; mem[1] = 16'h0200; mem[2] = 16'hFE00;
        vec[0]  = {1'b1, 1'b0, 4'b0000, 8'd0, 16'd0};
        vec[1]  = {1'b0, 1'b1, 4'b1100, 8'd0, 16'd0};
        vec[2]  = {1'b0, 1'b0, 4'b0100, 8'd0, 16'd0};
        vec[3]  = {1'b0, 1'b0, 4'b0100, 8'd0, 16'd0};
        vec[4]  = {1'b0, 1'b0, 4'b0101, 8'd0, 16'd0};
        vec[5]  = {1'b0, 1'b1, 4'b1100, 8'd1, 16'd1};
        vec[6]  = {1'b0, 1'b0, 4'b0100, 8'd1, 16'd1};
        vec[7]  = {1'b0, 1'b0, 4'b0100, 8'd1, 16'd1};
        vec[8]  = {1'b0, 1'b0, 4'b0101, 8'd1, 16'd1};
        vec[9]  = {1'b0, 1'b1, 4'b1100, 8'd2, 16'd2};
        vec[10] = {1'b0, 1'b0, 4'b0100, 8'd2, 16'd2};
        vec[11] = {1'b0, 1'b0, 4'b0010, 8'd2, 16'd2};
        vec[12] = {1'b0, 1'b0, 4'b0010, 8'd2, 16'd2};
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("zw_cycle%0d", i), snap(), {4'b0, vec[i][27:0]});
            start = vec[i].start;
            r_rdy = vec[i].rdy;
            tick();
        end

        // Three wait states on the first fetch, launched from HALT.
        r_rdy = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("ws_restart", {halted, pc, retired}, 25'h0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("ws_req_c%0d", c), {imem_req, imem_addr}, {1'b1, 8'd0});
            if (c == 4) r_rdy = 1'b1;
            tick();
        end
        chk("ws_rf_c5", {1'b0, rf_we}, 2'b00);
        tick();
        chk("ws_rf_c6", {1'b0, rf_we}, 2'b00);
        tick();
        chk("ws_rf_c7", {busy, rf_we}, 2'b11);
        for (int i = 0; i < 60; i++) begin
            if (halted) break;
            tick();
        end
        chk("ws_drain_halt", {halted, pc, retired}, {1'b1, 8'd2, 16'd2});

        // Randomized programs with random wait states, each restarted from HALT.
        for (int run = 0; run < 6; run++) begin
            nprog = $urandom_range(3, 12);
            for (int k = 0; k < nprog; k++) begin
                prog[k] = 16'($urandom);
                if (k == nprog - 1) prog[k][15:9] = 7'h7F;
                else if (prog[k][15:9] == 7'h7F) prog[k][9] = 1'b0;
                wts[k] = $urandom_range(0, 3);
                mem[k] = prog[k];
            end
            build_timeline();
            for (int c = 0; c < tlen; c++) begin
                if (c > 0) begin
                    chk($sformatf("rnd%0d_c%0d", run, c), snap(), {4'b0, tl[c]});
                    if (!tl[c].req)
                        chk($sformatf("rnd%0d_ins_c%0d", run, c), {16'h0, ins}, {16'h0, ins_s[c]});
                end
                start = (c == 0);
                r_rdy = rdy_s[c];
                tick();
            end
            start = 1'b0;
        end

        // PC wrap on the PC_W=2 instance with four NOPs.
        w2_start = 1'b1; tick(); w2_start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c % 4 == 0)
                chk($sformatf("wrap_nowe_c%0d", c), {1'b0, w2_rf_we}, 2'b00);
            if (c == 16)
                chk("wrap_pc3_wb", {14'h0, w2_pc, w2_ret}, {14'h0, 2'd3, 16'd3});
            if (c == 17)
                chk("wrap_fifth_fetch", {w2_req, w2_addr, w2_pc, w2_ret}, {1'b1, 2'd0, 2'd0, 16'd4});
            if (c < 17) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
